// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_SEL_INC,
      PC_SEL_HOLD,
      PC_SEL_BR,
      PC_SEL_CALL,
      PC_SEL_RET
   } pc_sel_t;

   localparam int unsigned INC_DEF = 4;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

   // Fixed redirect priority: branch > call > return > freeze > increment.
   function automatic pc_sel_t pc_select(
      input logic br,
      input logic call,
      input logic ret,
      input logic frz
   );
      pc_sel_t sel;
      if (br) begin
         sel = PC_SEL_BR;
      end else if (call) begin
         sel = PC_SEL_CALL;
      end else if (ret) begin
         sel = PC_SEL_RET;
      end else if (frz) begin
         sel = PC_SEL_HOLD;
      end else begin
         sel = PC_SEL_INC;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Request/status bundle between the pipeline control and the PC unit.
interface pc_unit_if #(
   parameter int unsigned WIDTH = 32
);

   logic             freeze;
   logic             branch_taken;
   logic [WIDTH-1:0] branch_addr;
   logic             call_valid;
   logic [WIDTH-1:0] call_target;
   logic [WIDTH-1:0] call_link;
   logic             ret_valid;
   logic [WIDTH-1:0] ret_target;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_overflow;

   modport master (
      output freeze,
      output branch_taken,
      output branch_addr,
      output call_valid,
      output call_target,
      output call_link,
      output ret_valid,
      output ret_target,
      input  pc,
      input  pc_next,
      input  ras_empty,
      input  ras_full,
      input  ras_overflow
   );

   modport slave (
      input  freeze,
      input  branch_taken,
      input  branch_addr,
      input  call_valid,
      input  call_target,
      input  call_link,
      input  ret_valid,
      input  ret_target,
      output pc,
      output pc_next,
      output ras_empty,
      output ras_full,
      output ras_overflow
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry and raises a sticky overflow flag.
module pc_ras #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             overflow_o
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0] FULLC = CW'(RAS_DEPTH);

   if (RAS_DEPTH < 2) begin : g_bad_depth
      $error("pc_ras: RAS_DEPTH must be at least 2");
   end

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]    top_q, top_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             empty, full;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULLC);

   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push_i) begin
         top_d = (top_q == LAST) ? '0 : top_q + 1'b1;
         cnt_d = full ? cnt_q : cnt_q + 1'b1;
         ovf_d = ovf_q | full;
      end else if (pop_i && !empty) begin
         top_d = (top_q == '0) ? LAST : top_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Entry storage needs no reset: it is only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[top_d] <= data_i;
      end
   end

   assign top_o      = mem_q[top_q];
   assign empty_o    = empty;
   assign full_o     = full;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
   parameter int unsigned      INC          = INC_DEF,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input logic     clk,
   input logic     rst,
   pc_unit_if.slave bus
);

   pc_sel_t          sel;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty, ras_full, ras_ovf;

   assign sel = pc_select(bus.branch_taken, bus.call_valid,
                          bus.ret_valid, bus.freeze);

   assign pc_inc = pc_q + WIDTH'(INC);

`ifdef PC_RAS_EN
   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk        (clk),
      .rst        (rst),
      .push_i     (sel == PC_SEL_CALL),
      .pop_i      (sel == PC_SEL_RET),
      .data_i     (bus.call_link),
      .top_o      (ras_top),
      .empty_o    (ras_empty),
      .full_o     (ras_full),
      .overflow_o (ras_ovf)
   );
`else
   logic unused_link;
   assign unused_link = ^bus.call_link;
   assign ras_top     = '0;
   assign ras_empty   = 1'b1;
   assign ras_full    = 1'b0;
   assign ras_ovf     = 1'b0;
`endif

   assign ret_addr = ras_empty ? bus.ret_target : ras_top;

   always_comb begin
      pc_d = pc_inc;
      unique case (sel)
         PC_SEL_BR:   pc_d = bus.branch_addr;
         PC_SEL_CALL: pc_d = bus.call_target;
         PC_SEL_RET:  pc_d = ret_addr;
         PC_SEL_HOLD: pc_d = pc_q;
         PC_SEL_INC:  pc_d = pc_inc;
         default:     pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_next      = pc_inc;
   assign bus.ras_empty    = ras_empty;
   assign bus.ras_full     = ras_full;
   assign bus.ras_overflow = ras_ovf;

endmodule

// File: tb/tb_pc_unit.sv
// Randomised self-checking bench for pc_unit against a queue-based model.
module tb_pc_unit;

   localparam int unsigned W     = 32;
   localparam logic [31:0] RV    = 32'h0000_0100;
   localparam int unsigned DEPTH = 4;
`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   pc_unit_if #(.WIDTH(W)) bus ();

   pc_unit #(
      .WIDTH        (W),
      .RESET_VECTOR (RV),
      .INC          (4),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   bit          m_ovf;

   function automatic logic [2:0] exp_flags();
      logic e, f, o;
      e = RAS_EN ? (m_ras.size() == 0) : 1'b1;
      f = RAS_EN ? (m_ras.size() == DEPTH) : 1'b0;
      o = RAS_EN ? m_ovf : 1'b0;
      return {e, f, o};
   endfunction

   task automatic model_reset();
      m_pc  = RV;
      m_ras.delete();
      m_ovf = 1'b0;
   endtask

   task automatic drive(input bit fr, input bit br, input logic [31:0] ba,
                        input bit cv, input logic [31:0] ct,
                        input logic [31:0] cl, input bit rv,
                        input logic [31:0] rt);
      bus.freeze       = fr;
      bus.branch_taken = br;
      bus.branch_addr  = ba;
      bus.call_valid   = cv;
      bus.call_target  = ct;
      bus.call_link    = cl;
      bus.ret_valid    = rv;
      bus.ret_target   = rt;
      @(posedge clk);
      #1;
      if (br) begin
         m_pc = ba;
      end else if (cv) begin
         m_pc = ct;
         if (RAS_EN) begin
            if (m_ras.size() == DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
            m_ras.push_back(cl);
         end
      end else if (rv) begin
         if (RAS_EN && m_ras.size() > 0) m_pc = m_ras.pop_back();
         else m_pc = rt;
      end else if (!fr) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      rst = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (bus.pc !== 32'h100) begin
         n_err++;
         $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h100);
      end
      n_cmp++;
      if ({bus.ras_empty, bus.ras_full, bus.ras_overflow} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 100",
                  {bus.ras_empty, bus.ras_full, bus.ras_overflow});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle();
         exp = RV + 32'(4 * (i + 1));
         n_cmp++;
         if (bus.pc !== exp) begin
            n_err++;
            $display("FAIL reset_run%0d: got %h want %h", i, bus.pc, exp);
         end
      end
      drive(0, 0, 0, 1, 32'h2000, 32'h44, 0, 0);
      drive(0, 0, 0, 1, 32'h3000, 32'h48, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (bus.pc !== 32'h100 ||
          {bus.ras_empty, bus.ras_full, bus.ras_overflow} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_mid: got pc %h flags %b want 100/100", bus.pc,
                  {bus.ras_empty, bus.ras_full, bus.ras_overflow});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_freeze_branch();
      logic [31:0] held;
      idle();
      held = bus.pc;
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0);
         n_cmp++;
         if (bus.pc !== held || bus.pc !== m_pc) begin
            n_err++;
            $display("FAIL freeze_hold%0d: got %h want %h", i, bus.pc, held);
         end
      end
      drive(1, 1, 32'h400, 0, 0, 0, 0, 0);
      n_cmp++;
      if (bus.pc !== 32'h400) begin
         n_err++;
         $display("FAIL freeze_branch: got %h want 400", bus.pc);
      end
   endtask

   task automatic test_priority();
      logic [31:0] exp;
      do_reset();
      drive(0, 1, 32'h800, 1, 32'h900, 32'hA0, 1, 32'hB00);
      n_cmp++;
      if (bus.pc !== 32'h800) begin
         n_err++;
         $display("FAIL prio_all: got %h want 800", bus.pc);
      end
      n_cmp++;
      if ({bus.ras_empty, bus.ras_full, bus.ras_overflow} !== exp_flags()) begin
         n_err++;
         $display("FAIL prio_all_flags: got %b want %b",
                  {bus.ras_empty, bus.ras_full, bus.ras_overflow}, exp_flags());
      end
      drive(0, 0, 0, 1, 32'hC00, 32'hC4, 1, 32'hD00);
      n_cmp++;
      if (bus.pc !== 32'hC00) begin
         n_err++;
         $display("FAIL prio_call_ret: got %h want c00", bus.pc);
      end
      n_cmp++;
      if (bus.ras_empty !== !RAS_EN) begin
         n_err++;
         $display("FAIL prio_push: got empty %b want %b", bus.ras_empty, !RAS_EN);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
      exp = RAS_EN ? 32'hC4 : 32'hDEAD;
      n_cmp++;
      if (bus.pc !== exp) begin
         n_err++;
         $display("FAIL prio_ret1: got %h want %h", bus.pc, exp);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
      n_cmp++;
      if (bus.pc !== 32'hDEAD) begin
         n_err++;
         $display("FAIL prio_ret2: got %h want dead", bus.pc);
      end
   endtask

   task automatic test_ras_roundtrip();
      logic [31:0] links [3];
      logic [31:0] exp;
      links = '{32'h10, 32'h20, 32'h30};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, {$urandom} & 32'hFFFF_FFFC, links[i], 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
         exp = (RAS_EN && i < 3) ? links[2-i] : 32'hDEAD;
         n_cmp++;
         if (bus.pc !== exp) begin
            n_err++;
            $display("FAIL ras_ret%0d: got %h want %h", i, bus.pc, exp);
         end
      end
      n_cmp++;
      if (bus.ras_empty !== 1'b1) begin
         n_err++;
         $display("FAIL ras_empty_after: got %b want 1", bus.ras_empty);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 1, 32'h4000 + 32'(i * 16), 32'(i), 0, 0);
      end
      n_cmp++;
      if (bus.ras_full !== RAS_EN || bus.ras_overflow !== RAS_EN) begin
         n_err++;
         $display("FAIL ovf_flags: got full %b ovf %b want %b", bus.ras_full,
                  bus.ras_overflow, RAS_EN);
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 32'hBEE0);
         exp = (RAS_EN && i < 4) ? 32'(5 - i) : 32'hBEE0;
         n_cmp++;
         if (bus.pc !== exp) begin
            n_err++;
            $display("FAIL ovf_ret%0d: got %h want %h", i, bus.pc, exp);
         end
      end
      n_cmp++;
      if (bus.ras_overflow !== RAS_EN || bus.ras_empty !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_sticky: got ovf %b empty %b want %b 1",
                  bus.ras_overflow, bus.ras_empty, RAS_EN);
      end
   endtask

   task automatic test_wrap();
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      n_cmp++;
      if (bus.pc_next !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_next: got %h want 0", bus.pc_next);
      end
      idle();
      n_cmp++;
      if (bus.pc !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_pc: got %h want 0", bus.pc);
      end
   endtask

   task automatic test_back_to_back();
      bit fr, br, cv, rv;
      for (int i = 0; i < 400; i++) begin
         fr = ($urandom_range(3) == 0);
         br = ($urandom_range(7) == 0);
         cv = ($urandom_range(4) == 0);
         rv = ($urandom_range(3) == 0);
         drive(fr, br, $urandom, cv, $urandom, $urandom, rv, $urandom);
         n_cmp++;
         if (bus.pc !== m_pc || bus.pc_next !== m_pc + 32'd4) begin
            n_err++;
            $display("FAIL rand_pc%0d: got %h/%h want %h/%h", i, bus.pc,
                     bus.pc_next, m_pc, m_pc + 32'd4);
         end
         n_cmp++;
         if ({bus.ras_empty, bus.ras_full, bus.ras_overflow} !== exp_flags()) begin
            n_err++;
            $display("FAIL rand_flags%0d: got %b want %b", i,
                     {bus.ras_empty, bus.ras_full, bus.ras_overflow},
                     exp_flags());
         end
      end
   endtask

   initial begin
      bus.freeze       = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_addr  = '0;
      bus.call_valid   = 1'b0;
      bus.call_target  = '0;
      bus.call_link    = '0;
      bus.ret_valid    = 1'b0;
      bus.ret_target   = '0;
      model_reset();
      #12;
      test_reset();
      test_freeze_branch();
      test_priority();
      test_ras_roundtrip();
      test_overflow();
      test_wrap();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
